// File: rtl/inv_clarke_seq.sv
// rtl/inv_clarke_seq.sv - sequential inverse Clarke transform, one shared multiplier
module inv_clarke_seq #(
  parameter int WIDTH           = 10,
  parameter int FRACTIONAL_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] alpha,
  input  logic signed [WIDTH-1:0] beta,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] a,
  output logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] c,
  output logic                    sat
);

  localparam int PW = WIDTH + FRACTIONAL_BITS + 1;
  localparam int EW = WIDTH + 2;

  // floor(sqrt(x)) by bit-wise search; keeps the constant exact without real math
  function automatic longint isqrt(input longint x);
    longint r;
    longint t;
    r = 0;
    for (int bp = FRACTIONAL_BITS + 2; bp >= 0; bp--) begin
      t = r | (longint'(1) << bp);
      if (t * t <= x) r = t;
    end
    return r;
  endfunction

  // K = floor(2^F * sqrt(3)/2) = floor(sqrt(3 * 4^F) / 2)
  localparam longint KL = isqrt(longint'(3) << (2 * FRACTIONAL_BITS)) / 2;
  localparam logic signed [PW-1:0] KC = PW'(KL);

  localparam logic signed [EW-1:0] MAXV = EW'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [EW-1:0] MINV = EW'(-(1 << (WIDTH - 1)));

  typedef enum logic [1:0] {IDLE, MUL, SUM, HOLD} state_t;

  state_t                  state;
  logic signed [WIDTH-1:0] alpha_r;
  logic signed [WIDTH-1:0] beta_r;
  logic signed [PW-1:0]    p_r;

  logic signed [PW-1:0]    beta_ext;
  logic signed [PW-1:0]    p_shift;
  logic signed [EW-1:0]    s_ext;
  logic signed [EW-1:0]    alpha_ext;
  logic signed [EW-1:0]    h_ext;
  logic signed [EW-1:0]    b_full;
  logic signed [EW-1:0]    c_full;
  logic                    b_clip;
  logic                    c_clip;
  logic signed [WIDTH-1:0] b_sat;
  logic signed [WIDTH-1:0] c_sat;

  assign in_ready = (state == IDLE);

  // clip a wide intermediate into the WIDTH output range
  function automatic logic [WIDTH:0] clip(input logic signed [EW-1:0] v);
    logic signed [EW-1:0] r;
    logic                 f;
    r = v;
    f = 1'b0;
    if (v > MAXV) begin
      r = MAXV;
      f = 1'b1;
    end else if (v < MINV) begin
      r = MINV;
      f = 1'b1;
    end
    return {f, r[WIDTH-1:0]};
  endfunction

  // SUM-stage arithmetic from the captured alpha and registered product
  always_comb begin
    beta_ext  = PW'(beta_r);
    p_shift   = p_r >>> FRACTIONAL_BITS;
    s_ext     = EW'(p_shift);
    alpha_ext = EW'(alpha_r);
    h_ext     = alpha_ext >>> 1;
    b_full    = s_ext - h_ext;
    c_full    = -s_ext - h_ext;
    {b_clip, b_sat} = clip(b_full);
    {c_clip, c_sat} = clip(c_full);
  end

  // control FSM with all datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      alpha_r   <= '0;
      beta_r    <= '0;
      p_r       <= '0;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            alpha_r <= alpha;
            beta_r  <= beta;
            state   <= MUL;
          end
        end
        MUL: begin
          p_r   <= beta_ext * KC;
          state <= SUM;
        end
        SUM: begin
          a         <= alpha_r;
          b         <= b_sat;
          c         <= c_sat;
          sat       <= b_clip | c_clip;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_clarke_seq.sv
// tb/tb_inv_clarke_seq.sv - directed table-driven bench for inv_clarke_seq
module tb_inv_clarke_seq;

  localparam int W = 10;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] alpha;
  logic signed [W-1:0] beta;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] a;
  logic signed [W-1:0] b;
  logic signed [W-1:0] c;
  logic                sat;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int al;
    int be;
    int ea;
    int eb;
    int ec;
    int es;
  } vec_t;

  vec_t vecs [9];

  inv_clarke_seq #(.WIDTH(W), .FRACTIONAL_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alpha(alpha), .beta(beta),
    .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .c(c), .sat(sat)
  );

  // free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("in_ready_timeout", int'(in_ready), 1);
  endtask

  task automatic check_outs(input string tag, input int ea, input int eb, input int ec, input int es);
    check({tag, "_a"}, int'(a), ea);
    check({tag, "_b"}, int'(b), eb);
    check({tag, "_c"}, int'(c), ec);
    check({tag, "_sat"}, int'(sat), es);
  endtask

  // accept one sample and check the 2-edge latency and result values
  task automatic run_vec(input string tag, input vec_t v);
    wait_ready();
    alpha    = W'(v.al);
    beta     = W'(v.be);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_busy"}, int'(in_ready), 0);
    check({tag, "_ov_e0"}, int'(out_valid), 0);
    tick();
    check({tag, "_ov_e1"}, int'(out_valid), 0);
    tick();
    check({tag, "_ov_e2"}, int'(out_valid), 1);
    check_outs(tag, v.ea, v.eb, v.ec, v.es);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ov_done"}, int'(out_valid), 0);
    check({tag, "_rdy_done"}, int'(in_ready), 1);
  endtask

  initial begin
    vecs[0] = '{100,    0,  100,  -50,  -50, 0};
    vecs[1] = '{0,    100,    0,   86,  -86, 0};
    vecs[2] = '{-101,   0, -101,   51,   51, 0};
    vecs[3] = '{-512, 511, -512,  511, -185, 1};
    vecs[4] = '{511, -512,  511, -512,  187, 1};
    vecs[5] = '{-1,    -1,   -1,    0,    2, 0};
    vecs[6] = '{3,      1,    3,   -1,   -1, 0};
    vecs[7] = '{0,   -100,    0,  -87,   87, 0};
    vecs[8] = '{-512,-512, -512, -186,  511, 1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alpha     = '0;
    beta      = '0;
    repeat (3) tick();
    check("rst_ov", int'(out_valid), 0);
    check_outs("rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", int'(in_ready), 1);

    for (int i = 0; i < 9; i++) begin
      run_vec($sformatf("v%0d", i), vecs[i]);
      handshake($sformatf("v%0d", i));
    end

    // backpressure: result held, new sample refused while busy
    run_vec("bp", vecs[3]);
    alpha    = W'(7);
    beta     = W'(0);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_hold_ov", int'(out_valid), 1);
      check("bp_hold_rdy", int'(in_ready), 0);
      check_outs("bp_hold", -512, 511, -185, 1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_ov", int'(out_valid), 0);
    check("bp_release_rdy", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("bp_accept_busy", int'(in_ready), 0);
    tick();
    check("bp_new_ov_e1", int'(out_valid), 0);
    tick();
    check("bp_new_ov_e2", int'(out_valid), 1);
    check_outs("bp_new", 7, -3, -3, 0);
    handshake("bp_new");

    // reset while in SUM discards the sample
    alpha    = W'(200);
    beta     = W'(50);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_ov", int'(out_valid), 0);
    check_outs("mid_rst", 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    check("mid_rst_rdy", int'(in_ready), 1);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("mid_rst_no_stale", int'(out_valid), 0);
    end
    check("mid_rst_rdy_end", int'(in_ready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inv_clarke_seq.md
Name: inv_clarke_seq

Overview:
- Inverse Clarke transform: converts stationary-frame (alpha, beta) into three-phase quantities (a, b, c) for the modulator/PWM stage.
- Sits downstream of the inverse Park block and feeds SVPWM/SPWM duty generation.
- Uses one registered multiplier behind a small FSM with valid/ready handshakes on both sides.
- Signed fixed-point throughout. Q-format is shared with the forward Clarke path: same WIDTH, same FRACTIONAL_BITS.

Parameters:
- WIDTH, 10, signed data width of alpha, beta, a, b, c.
- FRACTIONAL_BITS, 8, fractional bits of the internal sqrt(3)/2 constant.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  alpha/beta valid.
- in_ready  output  1  block can accept a sample.
- alpha  input  WIDTH  signed alpha component.
- beta  input  WIDTH  signed beta component.
- out_valid  output  1  a/b/c valid.
- out_ready  input  1  downstream accepts result.
- a  output  WIDTH  signed phase A.
- b  output  WIDTH  signed phase B.
- c  output  WIDTH  signed phase C.
- sat  output  1  b or c was clipped for the current result.

Behaviour:
- Reset: clk is the only clock. rst_n is asynchronous and active-low.
  - While rst_n=0: state=IDLE; a=b=c=0; sat=0; out_valid=0; internal registers cleared.
  - in_ready = (state==IDLE), so in_ready=1 from the first cycle after rst_n deasserts.
  - Reset mid-operation discards the in-flight sample; no output is produced for it.
- Constant: K = $rtoi((1<<FRACTIONAL_BITS)*$sqrt(3)/2), truncated. Default K=221.
- FSM states: IDLE, MUL, SUM, HOLD.
  - IDLE: in_ready=1. On in_valid at edge E: capture alpha and beta into registers; go to MUL.
  - MUL: P = K*beta_r, signed, WIDTH+FRACTIONAL_BITS+1 bits, registered at edge E+1; go to SUM.
  - SUM: compute and saturate, register a/b/c/sat at edge E+2; out_valid=1 after E+2; go to HOLD.
  - HOLD: outputs and out_valid held stable. On out_ready at edge H: out_valid=0 after H; go to IDLE.
  - out_ready sampled high on the same edge that sets out_valid is ignored. The handshake completes at the first edge with out_valid=1 and out_ready=1.
- Latency and throughput: out_valid rises 2 edges after the accepting edge. Maximum throughput is one sample per 4 cycles.
- in_ready=0 in MUL, SUM and HOLD. in_valid in those states is ignored and nothing is captured.
- Arithmetic, with intermediates sign-extended to WIDTH+2 bits:
  - S = P >>> FRACTIONAL_BITS (arithmetic shift, floor).
  - H = alpha_r >>> 1 (floor).
  - a = alpha_r. No clipping, always in range.
  - b_full = S - H.
  - c_full = -S - H.
- Saturation: b and c clip to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. sat=1 if either was clipped, else 0. sat updates with the outputs and is held with them.
- No combinational path from in_* to out_* or from out_ready to in_ready.

Test Plan:
- Basic alpha: alpha=100, beta=0 -> after 2 edges a=100, b=-50, c=-50, sat=0, out_valid=1.
- Beta scaling: alpha=0, beta=100 -> P=22100, S=86, so a=0, b=86, c=-86, sat=0.
- Floor on negative odd: alpha=-101, beta=0 -> H=-51, so a=-101, b=51, c=51.
- Saturation: alpha=-512, beta=511 -> P=112931, S=441, so b=511 clipped (raw 697), c=-185, a=-512, sat=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, and drive in_valid=1 with alpha=7.
  - Required: a/b/c/sat unchanged, in_ready=0, new sample not captured.
  - After out_ready=1 for one edge: out_valid=0, next cycle in_ready=1, and the sample alpha=7 is accepted.
- Reset mid-op: accept alpha=200, beta=50, then assert rst_n=0 while in SUM.
  - Required: immediately out_valid=0, a=b=c=0, sat=0.
  - After release: in_ready=1 and no stale result ever appears.
